// File: rtl/edge_pkg.sv
// Shared types and default sizing for the edge_event_capture block.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int DEF_CHANNELS      = 8;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_CNT_WIDTH     = 8;

endpackage

// File: rtl/edge_channel.sv
// One input channel: metastability synchroniser, stability filter and
// filtered-level edge detector producing single-cycle pulses.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_posedge,
    output logic data_negedge
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   synced;
    logic [FW-1:0]          filt_cnt_p1;
    logic                   filt_p1;
    logic                   filt_prev_p2;

    assign synced = sync_p0[SYNC_STAGES-1];

    // Stage 0: synchroniser chain; only the last flop is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], data_in};
        end
    end

    // Stage 1: level accepted only after FILTER_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_p1 <= '0;
            filt_p1     <= 1'b0;
        end else if (synced != filt_p1) begin
            if (filt_cnt_p1 == FILT_LAST) begin
                filt_p1     <= synced;
                filt_cnt_p1 <= '0;
            end else begin
                filt_cnt_p1 <= filt_cnt_p1 + FW'(1);
            end
        end else begin
            filt_cnt_p1 <= '0;
        end
    end

    // Stage 2: previous filtered level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_prev_p2 <= 1'b0;
        end else begin
            filt_prev_p2 <= filt_p1;
        end
    end

    assign data_posedge =  filt_p1 & ~filt_prev_p2;
    assign data_negedge = ~filt_p1 &  filt_prev_p2;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge capture: per-channel mode gating, sticky pending flags,
// saturating event counters, counter readback mux and combined interrupt.
module edge_event_capture
    import edge_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   data_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    input  logic [SEL_W-1:0]      count_sel,
    output logic [CHANNELS-1:0]   data_posedge,
    output logic [CHANNELS-1:0]   data_negedge,
    output logic [CHANNELS-1:0]   event_pending,
    output logic                  irq,
    output logic [CNT_WIDTH-1:0]  count_out
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CHANNELS-1:0]  evt;
    logic [CHANNELS-1:0]  pending_p3;
    logic [CNT_WIDTH-1:0] cnt_p3 [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_ext [2**SEL_W];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        edge_mode_t ch_mode;

        edge_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .data_in      (data_in[ch]),
            .data_posedge (data_posedge[ch]),
            .data_negedge (data_negedge[ch])
        );

        assign ch_mode = edge_mode_t'(mode[2*ch +: 2]);
        assign evt[ch] = (data_posedge[ch] & ((ch_mode == EDGE_RISE) || (ch_mode == EDGE_BOTH)))
                       | (data_negedge[ch] & ((ch_mode == EDGE_FALL) || (ch_mode == EDGE_BOTH)));
    end

    // Stage 3: event bookkeeping; an event in the same cycle as clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_p3 <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_p3[ch] <= '0;
            end
        end else begin
            pending_p3 <= (pending_p3 & ~clear) | evt;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (clear[ch]) begin
                    cnt_p3[ch] <= evt[ch] ? CNT_WIDTH'(1) : '0;
                end else if (evt[ch]) begin
                    cnt_p3[ch] <= sat_inc(cnt_p3[ch]);
                end
            end
        end
    end

    // Selector codes beyond the last channel read back as zero.
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_sel
        if (i < CHANNELS) begin : g_real
            assign cnt_ext[i] = cnt_p3[i];
        end else begin : g_pad
            assign cnt_ext[i] = '0;
        end
    end

    assign count_out     = cnt_ext[count_sel];
    assign event_pending = pending_p3;
    assign irq           = |pending_p3;

endmodule
